// File: rtl/div_if.sv
// Divider request/result bundle between EX and the divider.
// EX is the master; the divider is the slave.
interface div_if #(
  parameter int WIDTH = 32
);
  logic               div_sign;
  logic [WIDTH-1:0]   opNum1_div;
  logic [WIDTH-1:0]   opNum2_div;
  logic               div_start;
  logic               annul;
  logic [2*WIDTH-1:0] div_res;
  logic               div_finish;

  modport master (
    output div_sign,
    output opNum1_div,
    output opNum2_div,
    output div_start,
    output annul,
    input  div_res,
    input  div_finish
  );

  modport slave (
    input  div_sign,
    input  opNum1_div,
    input  opNum2_div,
    input  div_start,
    input  annul,
    output div_res,
    output div_finish
  );
endinterface

// File: rtl/div.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Returns {remainder, quotient}; EX holds start until it sees finish.
module div #(
  parameter int WIDTH = 32
) (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {
    FREE,
    BYZERO,
    ON,
    END
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH:0]   w;
  logic [WIDTH-1:0]   dvsr;
  logic               q_neg;
  logic               r_neg;
  logic [2*WIDTH-1:0] res;
  logic               fin;

  logic [WIDTH-1:0] mag1;
  logic [WIDTH-1:0] mag2;
  logic [WIDTH+1:0] diff;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic             go;
  logic             stop;

  assign go   = bus.div_start && !bus.annul;
  assign stop = bus.annul || !bus.div_start;

  assign mag1 = (bus.div_sign && bus.opNum1_div[WIDTH-1])
              ? -bus.opNum1_div : bus.opNum1_div;
  assign mag2 = (bus.div_sign && bus.opNum2_div[WIDTH-1])
              ? -bus.opNum2_div : bus.opNum2_div;

  // Full 33-bit partial remainder so divisors >= 2^31 still divide exactly.
  assign diff = {1'b0, w[2*WIDTH:WIDTH]} - {2'b0, dvsr};

  assign quo   = w[WIDTH-1:0];
  assign rem   = w[2*WIDTH:WIDTH+1];
  assign quo_s = q_neg ? -quo : quo;
  assign rem_s = r_neg ? -rem : rem;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= FREE;
      cnt   <= '0;
      w     <= '0;
      dvsr  <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      res   <= '0;
      fin   <= 1'b0;
    end else begin
      unique case (state)
        FREE: begin
          res <= '0;
          fin <= 1'b0;
          if (go) begin
            dvsr  <= mag2;
            q_neg <= bus.div_sign &
                     (bus.opNum1_div[WIDTH-1] ^
                      bus.opNum2_div[WIDTH-1]);
            r_neg <= bus.div_sign &
                     bus.opNum1_div[WIDTH-1];
            w     <= {{WIDTH{1'b0}}, mag1, 1'b0};
            cnt   <= '0;
            state <= (mag2 == '0) ? BYZERO : ON;
          end
        end
        BYZERO: begin
          if (stop) begin
            state <= FREE;
          end else begin
            res   <= '0;
            fin   <= 1'b1;
            state <= END;
          end
        end
        ON: begin
          if (stop) begin
            state <= FREE;
          end else if (cnt != LAST) begin
            if (diff[WIDTH+1])
              w <= w << 1;
            else
              w <= {diff[WIDTH-1:0], w[WIDTH-1:0], 1'b1};
            cnt <= cnt + 1'b1;
          end else begin
            res   <= {rem_s, quo_s};
            fin   <= 1'b1;
            state <= END;
          end
        end
        END: begin
          if (!bus.div_start) begin
            res   <= '0;
            fin   <= 1'b0;
            state <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  assign bus.div_res    = res;
  assign bus.div_finish = fin;
endmodule

// File: tb/tb_div.sv
// Directed and randomized checks of the divider against a
// plain-arithmetic reference model.
module tb_div;
  logic clk;
  logic rst;
  int   tests;
  int   fails;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] ref_div(input logic s,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    longint x;
    longint y;
    longint q;
    longint r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      x = longint'($signed(a));
      y = longint'($signed(b));
    end else begin
      x = {32'd0, a};
      y = {32'd0, b};
    end
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // Drives a request and counts edges (including the sampling edge)
  // until finish; operands are scrambled after the first edge.
  task automatic do_op(input logic s,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       output logic [63:0] res,
                       output int lat);
    bus.div_sign   = s;
    bus.opNum1_div = a;
    bus.opNum2_div = b;
    bus.div_start  = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 1) begin
        bus.opNum1_div = $urandom;
        bus.opNum2_div = $urandom;
        bus.div_sign   = ~s;
      end
    end while (!bus.div_finish && lat < 100);
    res = bus.div_res;
  endtask

  task automatic release_start(input string tag);
    bus.div_start = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_fin_drop"}, {63'd0, bus.div_finish}, 64'd0);
    check({tag, "_res_drop"}, bus.div_res, 64'd0);
  endtask

  task automatic directed(input string tag,
                          input logic s,
                          input logic [31:0] a,
                          input logic [31:0] b,
                          input logic [63:0] exp,
                          input int exp_lat);
    logic [63:0] r;
    int          l;
    do_op(s, a, b, r, l);
    check({tag, "_lat"}, 64'(l), 64'(exp_lat));
    check({tag, "_res"}, r, exp);
  endtask

  initial begin
    logic [63:0] r;
    logic [63:0] held;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] rm;
    logic        s;
    logic        seen;
    int          l;
    longint      ar;
    longint      ad;

    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.div_sign   = 1'b0;
    bus.opNum1_div = '0;
    bus.opNum2_div = '0;
    bus.div_start  = 1'b0;
    bus.annul      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_fin", {63'd0, bus.div_finish}, 64'd0);
    check("reset_res", bus.div_res, 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed("udiv", 1'b0, 32'hFFFF_FFFF, 32'd2,
             {32'h0000_0001, 32'h7FFF_FFFF}, 34);
    release_start("udiv");
    directed("sdiv_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2,
             {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 34);
    release_start("sdiv_m7_2");
    directed("sdiv_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE,
             {32'h0000_0001, 32'hFFFF_FFFD}, 34);
    release_start("sdiv_7_m2");
    directed("byzero", 1'b0, 32'd1234, 32'd0, 64'd0, 2);
    release_start("byzero");
    directed("ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF,
             {32'h0000_0000, 32'h8000_0000}, 34);

    // Hold start past finish; annul in END must not matter.
    held = {32'h0000_0000, 32'h8000_0000};
    for (int i = 0; i < 5; i++) begin
      bus.annul = (i == 2 || i == 3);
      @(posedge clk);
      #1;
      check("hold_res", bus.div_res, held);
      check("hold_fin", {63'd0, bus.div_finish}, 64'd1);
    end
    bus.annul = 1'b0;
    release_start("hold");
    directed("reissue", 1'b0, 32'd100, 32'd7,
             {32'h0000_0002, 32'h0000_000E}, 34);
    release_start("reissue");

    // Cancel after ten iterations.
    bus.div_sign   = 1'b0;
    bus.opNum1_div = 32'd1000;
    bus.opNum2_div = 32'd3;
    bus.div_start  = 1'b1;
    seen = 1'b0;
    repeat (11) begin
      @(posedge clk);
      #1;
      seen |= bus.div_finish;
    end
    bus.annul = 1'b1;
    @(posedge clk);
    #1;
    seen |= bus.div_finish;
    bus.annul     = 1'b0;
    bus.div_start = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      seen |= bus.div_finish;
    end
    check("annul_nofin", {63'd0, seen}, 64'd0);

    // Async reset mid-ON, between edges.
    bus.div_start = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_on_fin", {63'd0, bus.div_finish}, 64'd0);
    check("rst_on_res", bus.div_res, 64'd0);
    bus.div_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Async reset while a result is being held.
    directed("pre_rst", 1'b0, 32'd50, 32'd7,
             {32'd1, 32'd7}, 34);
    #2;
    rst = 1'b1;
    #1;
    check("rst_end_fin", {63'd0, bus.div_finish}, 64'd0);
    check("rst_end_res", bus.div_res, 64'd0);
    bus.div_start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    directed("after_rst", 1'b0, 32'd9, 32'd3,
             {32'd0, 32'd3}, 34);
    release_start("after_rst");

    for (int n = 0; n < 2000; n++) begin
      s = 1'($urandom);
      a = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) a = -a;
      b = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) b = -b;
      if (b == 32'd0) b = 32'd1;
      do_op(s, a, b, r, l);
      check("rnd_lat", 64'(l), 64'd34);
      check("rnd_res", r, ref_div(s, a, b));
      q  = r[31:0];
      rm = r[63:32];
      check("rnd_recon", {32'd0, q * b + rm}, {32'd0, a});
      if (s) begin
        ar = longint'($signed(rm));
        ad = longint'($signed(b));
        if (ar < 0) ar = -ar;
        if (ad < 0) ad = -ad;
      end else begin
        ar = {32'd0, rm};
        ad = {32'd0, b};
      end
      check("rnd_rem_bound", {63'd0, ar < ad}, 64'd1);
      bus.div_start = 1'b0;
      @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
